// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with a show-ahead receive FIFO.
//
// The receiver runs a per-bit cycle counter. It samples the start bit at
// its midpoint, then samples every later bit one bit time after the
// previous one. Optional parity and the stop bit are checked. Good words
// are queued. Bad frames raise sticky flags and are never queued.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   rx         - asynchronous serial input, idles high
//   datarx     - FIFO head word (0 while empty)
//   rcvd       - FIFO not empty
//   rxack      - pop the head word (ignored while empty)
//   count      - number of occupied FIFO entries
//   busy       - receive state machine not idle
//   frame_err  - sticky: a stop bit was sampled low
//   parity_err - sticky: parity mismatch
//   overrun    - sticky: a good word was dropped because the FIFO was full
//   rx_err     - OR of the three sticky flags
//   err_clr    - clear all sticky flags (a same-cycle new error wins)
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_WIDTH-1:0]         datarx,
  output logic                          rcvd,
  input  logic                          rxack,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          rx_err,
  input  logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam bit            ODD = (PARITY == 1);
  localparam bit            HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
  } state_t;

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [BW-1:0]           bit_reg, bit_next;
  logic [DATA_WIDTH-1:0]   shreg_reg, shreg_next;
  logic                    par_ok_reg, par_ok_next;
  logic                    rx_meta_reg, rxs;
  logic                    push, set_ferr, set_perr;

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]             count_reg;
  logic                    frame_err_reg, parity_err_reg, overrun_reg;
  logic                    full, pop, push_eff, set_ovr;

  // Two-flop synchroniser; both flops reset to the idle (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rxs         <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs         <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shreg_reg  <= '0;
      par_ok_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      shreg_reg  <= shreg_next;
      par_ok_reg <= par_ok_next;
    end
  end

  // cnt_reg counts down to zero; the sample is taken on the edge where it is
  // zero. Loading N-1 therefore places the sample N edges after the load.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    shreg_next  = shreg_reg;
    par_ok_next = par_ok_reg;
    push        = 1'b0;
    set_ferr    = 1'b0;
    set_perr    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!rxs) begin
          state_next = S_START;
          cnt_next   = HALF_M1;
        end
      end
      S_START: begin
        if (cnt_reg == '0) begin
          if (!rxs) begin
            state_next  = S_DATA;
            cnt_next    = BIT_M1;
            bit_next    = '0;
            par_ok_next = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_reg == '0) begin
          shreg_next = {rxs, shreg_reg[DATA_WIDTH-1:1]};
          cnt_next   = BIT_M1;
          if (bit_reg == LAST_BIT) begin
            state_next = HAS_PAR ? S_PAR : S_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_PAR: begin
        if (cnt_reg == '0) begin
          par_ok_next = ((^shreg_reg) ^ rxs) == ODD;
          cnt_next    = BIT_M1;
          state_next  = S_STOP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_reg == '0) begin
          if (rxs) begin
            push       = par_ok_reg;
            set_perr   = !par_ok_reg;
            state_next = S_IDLE;
          end else begin
            set_ferr   = 1'b1;
            state_next = S_BREAK;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A pop frees a slot on the same edge, so a push into a full FIFO succeeds
  // when a pop accompanies it. A pop from an empty FIFO is simply ignored.
  assign full     = (count_reg == FULL_CNT);
  assign pop      = rxack && (count_reg != '0);
  assign push_eff = push && (!full || pop);
  assign set_ovr  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr_reg] <= shreg_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (push_eff) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg      <= count_reg + {{AW{1'b0}}, push_eff} - {{AW{1'b0}}, pop};
      frame_err_reg  <= (frame_err_reg  && !err_clr) || set_ferr;
      parity_err_reg <= (parity_err_reg && !err_clr) || set_perr;
      overrun_reg    <= (overrun_reg    && !err_clr) || set_ovr;
    end
  end

  assign rcvd       = (count_reg != '0);
  assign datarx     = rcvd ? mem[rd_ptr_reg] : '0;
  assign count      = count_reg;
  assign busy       = (state_reg != S_IDLE);
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overrun    = overrun_reg;
  assign rx_err     = frame_err_reg || parity_err_reg || overrun_reg;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO, replacing the fixed 8-bit, single-buffer receive path behind `uart`/`echo`. It oversamples `rx` with a per-bit cycle counter and checks optional parity and the stop bit. Good words are queued in a show-ahead FIFO drained through the `rcvd`/`rxack` handshake. Framing, parity and overrun errors are reported as separate sticky flags.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, LSB first, range 5–9.
- `CLKS_PER_BIT`, 868: clock cycles per bit, minimum 4. The default is 115200 baud at 100 MHz.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, 4: number of FIFO entries; power of two, ≥2.
- `clk  in  1`: the single clock; all logic runs on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `rx  in  1`: serial input; asynchronous, idles high.
- `datarx  out  DATA_WIDTH`: FIFO head word, valid while `rcvd`=1.
- `rcvd  out  1`: FIFO not empty.
- `rxack  in  1`: pops one word on each clock where `rxack`=1 and `rcvd`=1.
- `count  out  $clog2(FIFO_DEPTH)+1`: number of occupied entries.
- `busy  out  1`: receive state machine is not in IDLE.
- `frame_err  out  1`: sticky; a stop bit was sampled as 0.
- `parity_err  out  1`: sticky; a parity mismatch occurred.
- `overrun  out  1`: sticky; a good word was dropped because the FIFO was full.
- `rx_err  out  1`: OR of the three error flags.
- `err_clr  in  1`: clears all sticky flags.

## Operation
- **Reset** (`rst_n`=0, immediate): state = IDLE, both synchroniser flops = 1, FIFO empty.
  - `rcvd`=0, `count`=0, `busy`=0, all error flags 0, `datarx`=0.
- **Synchroniser:** `rx` passes through two flops; `rxs` is the second flop and is the only version of `rx` the logic uses.
- **States:** IDLE, START, DATA, PAR, STOP, BREAK.
  - IDLE: `rxs`=0 → START; bit counter loaded for H = CLKS_PER_BIT/2 (floor).
  - START: after H cycles, sample `rxs`. If 0 → DATA; if 1 → IDLE (glitch, nothing recorded).
  - DATA: sample every CLKS_PER_BIT cycles. Shift in LSB first; after DATA_WIDTH samples → PAR if PARITY≠0, else → STOP.
  - PAR: one sample after CLKS_PER_BIT cycles. Even parity requires XOR(data, parity bit) = 0; odd requires 1. Record the result, then → STOP.
  - STOP: one sample after CLKS_PER_BIT cycles.
    - Sample = 1 and parity good → push the word, → IDLE.
    - Sample = 1 and parity bad → set `parity_err`, drop the word, → IDLE.
    - Sample = 0 → set `frame_err`, drop the word, → BREAK.
  - BREAK: wait until `rxs`=1, then → IDLE. A held-low line therefore never produces words.
- **FIFO:** circular buffer with DATA_WIDTH-wide entries and wrapping read/write pointers. `count` is kept as a register.
  - Push while full without a same-cycle pop → word dropped, `overrun` set.
  - Push and pop in the same cycle:
    - When full, both take effect and `overrun` is not set; `count` is unchanged.
    - When empty, the pop is ignored and the push takes effect; `count` = 1.
  - Pop while empty → ignored.
- **Sticky flags:** `err_clr`=1 clears all flags. If a new error occurs on the same edge, that flag ends set (set wins).
- **Reset mid-frame:** the partial word is discarded; the FIFO is cleared.

## Timing
- Let t0 be the edge on which IDLE sees `rxs`=0. This is 2–3 clocks after the `rx` falling edge.
- Bit k of the data (k = 0..DATA_WIDTH-1) is sampled at t0 + H + (k+1)·CLKS_PER_BIT.
- The parity bit is sampled at t0 + H + (DATA_WIDTH+1)·CLKS_PER_BIT.
- The stop bit is sampled at t0 + H + (DATA_WIDTH+P+1)·CLKS_PER_BIT, where P = (PARITY≠0).
- The push takes effect on the stop-sample edge:
  - `rcvd`, `datarx` and `count` are updated after that edge.
  - The error flags are set on that same edge.
- After a good stop sample the block is back in IDLE, so a start bit arriving half a bit later is accepted.
- Pop takes effect on the edge where `rxack`=1 and `rcvd`=1. The next word appears on `datarx` after that edge.
- `rxack` held high for n cycles pops up to n words.

## Test plan
- **Reset:** pulse `rst_n`=0 mid-frame, then send one frame → all outputs at their reset values immediately; the next frame is received cleanly.
- **Two words, then pop:** defaults, 10 ns clock. Send 0x8E twice (bits 0,1,1,1,0,0,0,1, 8681 ns per bit, stop bit = 1) with `rxack`=0 → `count`=2, `datarx`=0x8E. Pulse `rxack` for one cycle → `count`=1.
- **Glitch rejection:** drive `rx` low for 300 cycles, then high → no push; `busy` returns to 0; all error flags stay 0.
- **Framing error and recovery:** send 0x55 with stop bit = 0 → `frame_err`=1, `count` unchanged. Hold `rx` low for 20 bit times, release it, then send 0xA5 → 0xA5 is queued. Pulse `err_clr` → `rx_err`=0.
- **Even parity** (PARITY=2): send 0x8E with parity bit 0 → accepted. Send 0x8E with parity bit 1 → `parity_err`=1, word dropped.
- **Overrun** (FIFO_DEPTH=4):
  - Send 5 frames (0x01–0x05) without popping → `count`=4, `overrun`=1, `datarx`=0x01.
  - Repeat after reset with `rxack` pulsed on the 5th stop-sample edge → `overrun`=0, `count`=4, `datarx`=0x02.
